// File: rtl/cache_word_ctrl.sv
// Direct-mapped, write-through, one-word-per-line cache controller with a req/ready memory port.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_word_ctrl #(
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [3:0]          cpu_byte_w_en,
    output logic                cpu_ready,
    output logic [31:0]         cpu_rdata,
    output logic [INDEX_W-1:0]  arr_addr,
    output logic [31:0]         arr_wdata,
    output logic                arr_write,
    output logic [3:0]          arr_byte_w_en,
    input  logic [31:0]         arr_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_byte_w_en,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, WMEM, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [31:0]        rdata_q;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               refill_done;
    logic               unused_addr_bits;

    assign index            = cpu_addr[INDEX_W+1:2];
    assign tag              = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign hit              = valid[index] && (tags[index] == tag);
    assign refill_done      = (state == REFILL) && mem_ready;
    assign arr_addr         = index;
    assign unused_addr_bits = ^cpu_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (refill_done) begin
                valid[index] <= 1'b1;
                rdata_q      <= mem_rdata;
            end
        end
    end

    // Tags carry no meaning without their valid bit, so they are never reset.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tags[index] <= tag;
        end
    end

    always_comb begin
        next_state    = state;
        cpu_ready     = 1'b0;
        cpu_rdata     = rdata_q;
        arr_write     = 1'b0;
        arr_wdata     = cpu_wdata;
        arr_byte_w_en = cpu_byte_w_en;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata     = cpu_wdata;
        mem_byte_w_en = cpu_byte_w_en;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (!cpu_we) begin
                        if (hit) begin
                            cpu_ready = 1'b1;
                            cpu_rdata = arr_rdata;
                        end else begin
                            next_state = REFILL;
                        end
                    end else begin
                        // Write-through without allocate: only a resident line is updated.
                        arr_write  = hit;
                        next_state = WMEM;
                    end
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    arr_write     = 1'b1;
                    arr_byte_w_en = 4'hF;
                    arr_wdata     = mem_rdata;
                    next_state    = DONE;
                end
            end
            WMEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                cpu_ready  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic        accept;

    // Every access passes through IDLE exactly once, so counting there never double-counts.
    assign accept = (state == IDLE) && cpu_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (accept) begin
            if (hit) begin
                hits_q <= hits_q + 32'd1;
            end else begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: doc/cache_word_ctrl.md
Name: cache_word_ctrl

Overview:
Direct-mapped, write-through cache controller that sequences a one-word-per-line data array (7-bit line address, 32-bit word, per-byte write enables, combinational read, synchronous write). Sits between the CPU load/store stage and the main-memory port. Holds tag/valid state internally, drives the data-array control signals, and runs read-miss refills and write-through stores over a req/ready memory handshake.

Parameters:
INDEX_W, 7, line-index width; number of lines = 2^INDEX_W; must match the data-array address width.
ADDR_W, 32, CPU byte-address width; tag = cpu_addr[ADDR_W-1:INDEX_W+2], index = cpu_addr[INDEX_W+1:2].

Ports:
clk  in  1  single clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
cpu_req  in  1  request valid; held high until cpu_ready.
cpu_we  in  1  1 = store, 0 = load.
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
cpu_wdata  in  32  store data.
cpu_byte_w_en  in  4  store byte enables; bit i = byte i.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  32  load data, valid when cpu_ready and load.
arr_addr  out  INDEX_W  data-array line address.
arr_wdata  out  32  data-array write data.
arr_write  out  1  data-array write strobe.
arr_byte_w_en  out  4  data-array byte enables.
arr_rdata  in  32  data-array combinational read data.
mem_req  out  1  memory request; held until mem_ready.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  word-aligned memory address ([1:0] = 0).
mem_wdata  out  32  memory write data.
mem_byte_w_en  out  4  memory byte enables.
mem_ready  in  1  memory completion; for reads, mem_rdata valid same cycle.
mem_rdata  in  32  memory read data.
stat_hits  out  32  hit counter (see Optional Feature).
stat_misses  out  32  miss counter (see Optional Feature).

Behaviour:
- State machine: IDLE, REFILL, WMEM, DONE. Reset values: state = IDLE, all valid bits = 0, cpu_ready = 0, mem_req = 0, arr_write = 0, cpu_rdata register = 0.
- arr_addr = index of cpu_addr in every state. Hit = valid[index] and stored tag == addr tag.
- IDLE, no cpu_req: all strobes are 0.
- IDLE, load hit: cpu_ready = 1 combinationally in the same cycle; cpu_rdata = arr_rdata. Zero-wait hit. Stay in IDLE.
- IDLE, load miss: go to REFILL; cpu_ready = 0.
- IDLE, store:
  - On a hit, arr_write = 1 for exactly this cycle, with arr_wdata = cpu_wdata and arr_byte_w_en = cpu_byte_w_en.
  - On a miss, no array write (no write-allocate).
  - In both cases go to WMEM.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00}, held until mem_ready.
  - On mem_ready: arr_write = 1, arr_byte_w_en = 4'hF, arr_wdata = mem_rdata; tag[index] updated and valid[index] set at the clock edge; mem_rdata latched into cpu_rdata register; go to DONE.
- WMEM:
  - mem_req = 1, mem_we = 1, mem_wdata = cpu_wdata, mem_byte_w_en = cpu_byte_w_en, held until mem_ready.
  - On mem_ready, go to DONE.
- DONE: cpu_ready = 1 for exactly one cycle; cpu_rdata = latched register; go to IDLE unconditionally. cpu_req in DONE is not treated as a new request.
- Latency: load hit 0 cycles (ready same cycle); load miss = memory latency + 2; store = memory latency + 2.
- mem_req never drops before mem_ready. mem_ready while mem_req = 0 is ignored.
- cpu_addr, cpu_we, cpu_wdata and cpu_byte_w_en must be stable while cpu_req is high and cpu_ready is low. The controller does not re-register them.
- Reset mid-transaction: state returns to IDLE, mem_req drops next cycle, all valid bits are cleared, and the outstanding memory transaction is abandoned.
- Address wrap: none; all address fields are pure bit slices.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - stat_hits increments on each IDLE load hit and each IDLE store hit.
  - stat_misses increments on each IDLE load miss and each IDLE store miss.
  - Each access is counted exactly once, in the IDLE cycle it is accepted.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both ports tied to 0 and no counter registers are built.

Test Plan:
- After rst, load 0x0000_0040 with mem_ready 3 cycles later and mem_rdata = 0xDEAD_BEEF -> mem_req high for 3 cycles at mem_addr 0x40; cpu_ready pulses 1 cycle after mem_ready with cpu_rdata = 0xDEAD_BEEF.
- Repeat the load of 0x40 -> cpu_ready in the same cycle, cpu_rdata = 0xDEAD_BEEF, mem_req stays 0.
- Store 0x40 with cpu_byte_w_en = 4'b0010 and cpu_wdata = 0x0000_AA00, then load 0x40 -> array holds 0xDEAD_AAEF; memory write has byte enables 0010; the following load hits and returns 0xDEAD_AAEF.
- Load 0x240 (same index, different tag) -> miss, refill replaces the line; a subsequent load of 0x40 misses again.
- Assert rst during REFILL -> mem_req is 0 the next cycle, state is IDLE, and a load of 0x240 misses.
- With CACHE_STATS_EN defined, run the above sequence -> stat_hits and stat_misses equal the hand-counted totals; with the macro undefined, both read 0.
